// File: rtl/kyber_pkg.sv
// Shared Kyber constants, hash-select encodings and the pre-hash sequencer state type.
package kyber_pkg;

  localparam int KYBER_N    = 256;
  localparam int R_WIDTH    = 12;
  localparam int POLY_BYTES = R_WIDTH * KYBER_N / 8;

  localparam logic H_SHA3_256 = 1'b0;
  localparam logic H_SHA3_512 = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    REQ_M,
    WAIT_M,
    REQ_EK,
    WAIT_EK,
    REQ_G,
    WAIT_G,
    DONE
  } state_e;

  // Encapsulation-key size in bytes: k packed polynomials plus the rho seed.
  function automatic int ek_bytes(input int k);
    return k * POLY_BYTES + KYBER_N / 8;
  endfunction

endpackage

// File: rtl/kem_pre_hash_seq.sv
// Sequences the H(m), H(ek) and G(m || H(ek)) hash calls of ML-KEM encaps/decaps
// over a shared external SHA3 engine, caching H(ek) across encaps jobs.
module kem_pre_hash_seq
  import kyber_pkg::*;
#(
  parameter int KYBER_K = 3,
  parameter int KYBER_N = kyber_pkg::KYBER_N
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  output logic                                    busy,
  input  logic                                    mode,
  input  logic                                    ek_reuse,
  input  logic [KYBER_K*R_WIDTH*KYBER_N+KYBER_N-1:0] ek,
  input  logic [KYBER_N-1:0]                      rand_in,
  input  logic [KYBER_N-1:0]                      m_in,
  input  logic [KYBER_N-1:0]                      h_in,
  output logic [KYBER_N-1:0]                      msg,
  output logic [KYBER_N-1:0]                      hash_ek,
  output logic [KYBER_N-1:0]                      pre_k,
  output logic [KYBER_N-1:0]                      coin,
  output logic                                    valid,
  output logic                                    h_req,
  output logic                                    h_sel,
  output logic [15:0]                             h_len,
  output logic [KYBER_K*R_WIDTH*KYBER_N+KYBER_N-1:0] h_data,
  input  logic                                    h_ack,
  input  logic                                    h_done,
  input  logic [511:0]                            h_digest
);

  localparam int EK_W     = KYBER_K * R_WIDTH * KYBER_N + KYBER_N;
  localparam int EK_BYTES = EK_W / 8;

  localparam logic [15:0] LEN_H  = 16'(KYBER_N / 8);
  localparam logic [15:0] LEN_EK = 16'(EK_BYTES);
  localparam logic [15:0] LEN_G  = 16'(KYBER_N / 4);

  state_e              state_q, state_d;
  logic                valid_q, valid_d;
  logic [KYBER_N-1:0]  msg_q, msg_d;
  logic [KYBER_N-1:0]  hash_ek_q, hash_ek_d;
  logic [KYBER_N-1:0]  pre_k_q, pre_k_d;
  logic [KYBER_N-1:0]  coin_q, coin_d;
  logic [KYBER_N-1:0]  cache_q, cache_d;
  logic                cache_vld_q, cache_vld_d;
  logic                capture_en;

  logic                reuse_q;
  logic [KYBER_N-1:0]  rand_q;
  logic [EK_W-1:0]     ek_q;

  // NOTE: every always_comb output gets a default before the case so no path
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    msg_d       = msg_q;
    hash_ek_d   = hash_ek_q;
    pre_k_d     = pre_k_q;
    coin_d      = coin_q;
    cache_d     = cache_q;
    cache_vld_d = cache_vld_q;
    capture_en  = 1'b0;
    h_req       = 1'b0;
    h_sel       = H_SHA3_256;
    h_len       = '0;
    h_data      = '0;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          capture_en = 1'b1;
          valid_d    = 1'b0;
          if (mode) begin
            msg_d     = m_in;
            hash_ek_d = h_in;
            state_d   = REQ_G;
          end else begin
            state_d   = REQ_M;
          end
        end
      end
      REQ_M: begin
        h_req  = 1'b1;
        h_len  = LEN_H;
        h_data = EK_W'(rand_q);
        if (h_ack) state_d = WAIT_M;
      end
      WAIT_M: begin
        if (h_done) begin
          msg_d = h_digest[KYBER_N-1:0];
          if (reuse_q && cache_vld_q) begin
            hash_ek_d = cache_q;
            state_d   = REQ_G;
          end else begin
            state_d   = REQ_EK;
          end
        end
      end
      REQ_EK: begin
        h_req  = 1'b1;
        h_len  = LEN_EK;
        h_data = ek_q;
        if (h_ack) state_d = WAIT_EK;
      end
      WAIT_EK: begin
        if (h_done) begin
          hash_ek_d   = h_digest[KYBER_N-1:0];
          cache_d     = h_digest[KYBER_N-1:0];
          cache_vld_d = 1'b1;
          state_d     = REQ_G;
        end
      end
      REQ_G: begin
        h_req  = 1'b1;
        h_sel  = H_SHA3_512;
        h_len  = LEN_G;
        h_data = EK_W'({hash_ek_q, msg_q});
        if (h_ack) state_d = WAIT_G;
      end
      WAIT_G: begin
        if (h_done) begin
          pre_k_d = h_digest[KYBER_N-1:0];
          coin_d  = h_digest[2*KYBER_N-1:KYBER_N];
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      valid_q     <= 1'b0;
      msg_q       <= '0;
      hash_ek_q   <= '0;
      pre_k_q     <= '0;
      coin_q      <= '0;
      cache_q     <= '0;
      cache_vld_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      msg_q       <= msg_d;
      hash_ek_q   <= hash_ek_d;
      pre_k_q     <= pre_k_d;
      coin_q      <= coin_d;
      cache_q     <= cache_d;
      cache_vld_q <= cache_vld_d;
    end
  end

  // NOTE: the wide job-input capture is deliberately not reset; it is only
  // observed in REQ_* states, which are reachable solely through a capturing start.
  always_ff @(posedge clk) begin
    if (capture_en) begin
      reuse_q <= ek_reuse;
      rand_q  <= rand_in;
      ek_q    <= ek;
    end
  end

  assign busy    = (state_q != IDLE) && (state_q != DONE);
  assign valid   = valid_q;
  assign msg     = msg_q;
  assign hash_ek = hash_ek_q;
  assign pre_k   = pre_k_q;
  assign coin    = coin_q;

endmodule

// File: tb/tb_kem_pre_hash_seq.sv
// Self-checking bench: the bench plays the SHA3 engine with a stand-in digest and
// scores each hash request and each job result against queued expectations.
module tb_kem_pre_hash_seq;
  import kyber_pkg::*;

  localparam int K        = 3;
  localparam int N        = 256;
  localparam int EK_W     = K * R_WIDTH * N + N;
  localparam int EK_BYTES = EK_W / 8;
  localparam int EK_W2    = 2 * R_WIDTH * N + N;
  localparam int EK_W4    = 4 * R_WIDTH * N + N;

  typedef struct {
    logic            sel;
    int              len;
    logic [EK_W-1:0] data;
  } req_t;

  typedef struct {
    logic [N-1:0] msg;
    logic [N-1:0] hek;
    logic [N-1:0] pk;
    logic [N-1:0] coin;
  } res_t;

  logic            clk, rst, start, mode, ek_reuse;
  logic [EK_W-1:0] ek;
  logic [N-1:0]    rand_in, m_in, h_in;
  logic            busy, valid, h_req, h_sel;
  logic [N-1:0]    msg, hash_ek, pre_k, coin;
  logic [15:0]     h_len;
  logic [EK_W-1:0] h_data;
  logic            h_ack, h_done;
  logic [511:0]    h_digest;

  kem_pre_hash_seq #(.KYBER_K(K), .KYBER_N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .mode(mode), .ek_reuse(ek_reuse),
    .ek(ek), .rand_in(rand_in), .m_in(m_in), .h_in(h_in), .msg(msg), .hash_ek(hash_ek),
    .pre_k(pre_k), .coin(coin), .valid(valid), .h_req(h_req), .h_sel(h_sel),
    .h_len(h_len), .h_data(h_data), .h_ack(h_ack), .h_done(h_done), .h_digest(h_digest)
  );

  // Rank-2 and rank-4 instances, only probed for their H(ek) request length.
  logic             a_start, a_done;
  logic [EK_W2-1:0] a2_ek, a2_h_data;
  logic [EK_W4-1:0] a4_ek, a4_h_data;
  logic [N-1:0]     a2_msg, a2_hek, a2_pk, a2_coin, a4_msg, a4_hek, a4_pk, a4_coin;
  logic             a2_busy, a2_valid, a2_h_req, a2_h_sel, a4_busy, a4_valid, a4_h_req, a4_h_sel;
  logic [15:0]      a2_h_len, a4_h_len;

  kem_pre_hash_seq #(.KYBER_K(2), .KYBER_N(N)) dut_k2 (
    .clk(clk), .rst(rst), .start(a_start), .busy(a2_busy), .mode(1'b0), .ek_reuse(1'b0),
    .ek(a2_ek), .rand_in('0), .m_in('0), .h_in('0), .msg(a2_msg), .hash_ek(a2_hek),
    .pre_k(a2_pk), .coin(a2_coin), .valid(a2_valid), .h_req(a2_h_req), .h_sel(a2_h_sel),
    .h_len(a2_h_len), .h_data(a2_h_data), .h_ack(1'b1), .h_done(a_done), .h_digest('0)
  );

  kem_pre_hash_seq #(.KYBER_K(4), .KYBER_N(N)) dut_k4 (
    .clk(clk), .rst(rst), .start(a_start), .busy(a4_busy), .mode(1'b0), .ek_reuse(1'b0),
    .ek(a4_ek), .rand_in('0), .m_in('0), .h_in('0), .msg(a4_msg), .hash_ek(a4_hek),
    .pre_k(a4_pk), .coin(a4_coin), .valid(a4_valid), .h_req(a4_h_req), .h_sel(a4_h_sel),
    .h_len(a4_h_len), .h_data(a4_h_data), .h_ack(1'b1), .h_done(a_done), .h_digest('0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stand-in digest: deterministic mix of select, length and every data byte.
  // The full 512 bits are returned even for SHA3-256 so a wrong slice shows up.
  function automatic logic [511:0] fake_hash(input logic sel, input int len, input logic [EK_W-1:0] d);
    logic [511:0] acc;
    acc = {16{32'h9e3779b9}} ^ 512'(len) ^ (sel ? {8{64'h0123456789abcdef}} : '0);
    for (int i = 0; i < EK_BYTES; i++)
      acc = {acc[502:0], acc[511:503]} ^ (acc >> 13) ^ 512'(d[8*i +: 8]);
    return acc;
  endfunction

  req_t         exp_req_q[$];
  res_t         exp_res_q[$];
  logic [N-1:0] model_cache;
  logic         model_vld;

  int ack_hold   = 0;
  int done_delay = 24;
  int req_seen   = 0;
  bit rsp_busy   = 0;
  bit rsp_abort  = 0;

  logic [EK_W-1:0] rsp_snap;
  logic            rsp_sel;
  logic [15:0]     rsp_len;
  req_t            rsp_e;

  // Engine model: pops the expected request, checks it and its hold under
  // backpressure, acks, then returns the digest done_delay cycles after the ack.
  initial begin
    h_ack = 1'b0; h_done = 1'b0; h_digest = '0;
    @(negedge clk);
    forever begin
      while (rst || !h_req) @(negedge clk);
      rsp_busy = 1; req_seen++;
      rsp_snap = h_data; rsp_sel = h_sel; rsp_len = h_len;
      if (exp_req_q.size() == 0) begin
        check("unexpected_req", 512'(rsp_len), 512'(0));
      end else begin
        rsp_e = exp_req_q.pop_front();
        check("req_sel", 512'(rsp_sel), 512'(rsp_e.sel));
        check("req_len", 512'(rsp_len), 512'(rsp_e.len));
        check("req_data", fake_hash(1'b0, 0, rsp_snap), fake_hash(1'b0, 0, rsp_e.data));
      end
      for (int i = 0; i < ack_hold; i++) begin
        @(negedge clk);
        check("hold_req", 512'(h_req), 512'(1));
        check("hold_data", 512'(h_data == rsp_snap), 512'(1));
      end
      h_ack = 1'b1;
      @(negedge clk);
      h_ack = 1'b0;
      check("req_drop", 512'(h_req), 512'(0));
      repeat (done_delay - 1) @(negedge clk);
      h_done   = 1'b1;
      h_digest = fake_hash(rsp_sel, int'(rsp_len), rsp_snap);
      if (rsp_sel) check("valid_early", 512'(valid), 512'(0));
      @(negedge clk);
      h_done = 1'b0;
      if (rsp_sel) begin
        check("valid_rise", 512'(valid), 512'(1));
        check("busy_done", 512'(busy), 512'(0));
      end else if (!rsp_abort) begin
        check("req_after_done", 512'(h_req), 512'(1));
      end
      rsp_busy = 0;
    end
  end

  task automatic push_req(input logic sel, input int len, input logic [EK_W-1:0] d);
    req_t r;
    r.sel = sel; r.len = len; r.data = d;
    exp_req_q.push_back(r);
  endtask

  task automatic wait_valid();
    bit seen;
    seen = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (valid === 1'b1) begin seen = 1; break; end
    end
    if (!seen) check("valid_timeout", 512'(0), 512'(1));
  endtask

  task automatic run_job(input logic md, input logic reuse, input logic [EK_W-1:0] e,
                         input logic [N-1:0] r, input logic [N-1:0] m, input logic [N-1:0] h,
                         input int hold, input bit pulses);
    res_t         x, got;
    logic [511:0] d;
    if (!md) begin
      push_req(H_SHA3_256, N / 8, EK_W'(r));
      d = fake_hash(H_SHA3_256, N / 8, EK_W'(r));
      x.msg = d[N-1:0];
      if (reuse && model_vld) begin
        x.hek = model_cache;
      end else begin
        push_req(H_SHA3_256, EK_BYTES, e);
        d = fake_hash(H_SHA3_256, EK_BYTES, e);
        x.hek = d[N-1:0];
        model_cache = x.hek;
        model_vld = 1'b1;
      end
    end else begin
      x.msg = m;
      x.hek = h;
    end
    push_req(H_SHA3_512, N / 4, EK_W'({x.hek, x.msg}));
    d = fake_hash(H_SHA3_512, N / 4, EK_W'({x.hek, x.msg}));
    x.pk   = d[N-1:0];
    x.coin = d[2*N-1:N];
    exp_res_q.push_back(x);

    ack_hold = hold;
    @(negedge clk);
    mode = md; ek_reuse = reuse; ek = e; rand_in = r; m_in = m; h_in = h; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_start", 512'(busy), 512'(1));
    check("valid_clr", 512'(valid), 512'(0));
    check("req_after_start", 512'(h_req), 512'(1));
    if (pulses) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        mode = ~md; ek_reuse = ~reuse; ek = ~e; rand_in = ~r; m_in = ~m; h_in = ~h; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end
    wait_valid();
    repeat (3) @(negedge clk);
    got = exp_res_q.pop_front();
    check("out_msg", 512'(msg), 512'(got.msg));
    check("out_hash_ek", 512'(hash_ek), 512'(got.hek));
    check("out_pre_k", 512'(pre_k), 512'(got.pk));
    check("out_coin", 512'(coin), 512'(got.coin));
    check("valid_hold", 512'(valid), 512'(1));
    check("busy_idle", 512'(busy), 512'(0));
    check("req_q_empty", 512'(exp_req_q.size()), 512'(0));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 512'(busy), 512'(0));
    check({tag, "_valid"}, 512'(valid), 512'(0));
    check({tag, "_h_req"}, 512'(h_req), 512'(0));
    check({tag, "_h_sel"}, 512'(h_sel), 512'(0));
    check({tag, "_h_len"}, 512'(h_len), 512'(0));
    check({tag, "_h_data"}, 512'(h_data == '0), 512'(1));
    check({tag, "_msg"}, 512'(msg), 512'(0));
    check({tag, "_hash_ek"}, 512'(hash_ek), 512'(0));
    check({tag, "_pre_k"}, 512'(pre_k), 512'(0));
    check({tag, "_coin"}, 512'(coin), 512'(0));
  endtask

  logic [EK_W-1:0] ek_inc;
  logic [N-1:0]    m_seq, r_rnd;

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; ek_reuse = 1'b0;
    ek = '0; rand_in = '0; m_in = '0; h_in = '0;
    a_start = 1'b0; a_done = 1'b0; a2_ek = '0; a4_ek = '0;
    model_cache = '0; model_vld = 1'b0;
    for (int i = 0; i < EK_BYTES; i++) ek_inc[8*i +: 8] = 8'(i);
    for (int i = 0; i < N / 8; i++) m_seq[8*i +: 8] = 8'(i + 1);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_zero("reset");

    // Rank-2/4 instances: walk to REQ_EK and read its length.
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    @(negedge clk);
    a_done = 1'b1;
    @(negedge clk);
    a_done = 1'b0;
    check("k2_ek_req", 512'(a2_h_req), 512'(1));
    check("k2_ek_len", 512'(a2_h_len), 512'(800));
    check("k4_ek_len", 512'(a4_h_len), 512'(1568));

    run_job(1'b0, 1'b0, ek_inc, '0, '0, '0, 0, 0);
    run_job(1'b0, 1'b1, ek_inc, '0, '0, '0, 0, 0);
    run_job(1'b1, 1'b1, ek_inc, {8{32'h5a5a1234}}, m_seq, '1, 0, 0);
    for (int i = 0; i < N / 32; i++) r_rnd[32*i +: 32] = $urandom;
    run_job(1'b0, 1'b0, ~ek_inc, r_rnd, '0, '0, 5, 1);

    // Reset while waiting on H(ek); the engine's late h_done becomes a stray.
    rsp_abort = 1;
    ack_hold = 0;
    push_req(H_SHA3_256, N / 8, EK_W'(r_rnd));
    push_req(H_SHA3_256, EK_BYTES, ek_inc);
    begin
      int base;
      bit hit;
      base = req_seen; hit = 0;
      @(negedge clk);
      mode = 1'b0; ek_reuse = 1'b0; ek = ek_inc; rand_in = r_rnd; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk); #1;
        if (req_seen >= base + 2) begin hit = 1; break; end
      end
      if (!hit) check("ek_req_timeout", 512'(0), 512'(1));
    end
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_zero("midrst");
    begin
      bit idle;
      idle = 0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk); #1;
        if (!rsp_busy) begin idle = 1; break; end
      end
      if (!idle) check("stray_timeout", 512'(0), 512'(1));
    end
    @(negedge clk);
    check("stray_busy", 512'(busy), 512'(0));
    check("stray_h_req", 512'(h_req), 512'(0));
    check("stray_valid", 512'(valid), 512'(0));
    check("stray_msg", 512'(msg), 512'(0));
    exp_req_q.delete();
    exp_res_q.delete();
    model_cache = '0;
    model_vld = 1'b0;
    rsp_abort = 0;

    run_job(1'b0, 1'b1, ek_inc, ~r_rnd, '0, '0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
